// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO bridge: window base, register word offsets,
// STATUS/CTRL bit positions and the CTRL register layout.
package mmio_pkg;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_FF00;

    // Register offsets as word indices, i.e. DataAdr[7:2].
    localparam logic [5:0] OFF_GPIO_OUT  = 6'h00;
    localparam logic [5:0] OFF_GPIO_IN   = 6'h01;
    localparam logic [5:0] OFF_TIMER_CNT = 6'h02;
    localparam logic [5:0] OFF_TIMER_CMP = 6'h03;
    localparam logic [5:0] OFF_STATUS    = 6'h04;
    localparam logic [5:0] OFF_TX_DATA   = 6'h05;
    localparam logic [5:0] OFF_CTRL      = 6'h06;

    localparam int ST_MATCH     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_EMPTY     = 2;
    localparam int ST_OVERFLOW  = 3;
    localparam int ST_COUNT_LSB = 4;

    localparam int CTRL_TIMER_EN   = 0;
    localparam int CTRL_AUTO_CLEAR = 1;
    localparam int CTRL_IRQ_EN     = 2;

    typedef struct packed {
        logic irq_en;
        logic auto_clear;
        logic timer_en;
    } ctrl_t;

endpackage

// File: rtl/mmio_bridge_tx_fifo.sv
// Small synchronous FIFO feeding the serial transmitter; head is shown
// combinationally and reads as zero while empty.
module tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic             push_ok
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign push_ok = do_push;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/mmio_bridge.sv
// Data-port bridge for the single-cycle core: routes accesses to dmem or to a
// local register window holding GPIO, a compare timer and a TX FIFO.
module mmio_bridge
    import mmio_pkg::*;
#(
    parameter logic [31:0] IO_BASE    = IO_BASE_DEFAULT,
    parameter int          GPIO_W     = 8,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemWrite,
    input  logic [31:0]       DataAdr,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    output logic              dmem_we,
    input  logic [31:0]       dmem_rd,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              timer_irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic              io_sel;
    logic              io_wr;
    logic [5:0]        off;
    logic [31:0]       io_rdata;
    logic              unused_addr_bits;

    logic [GPIO_W-1:0] gpio_sync1;
    logic [GPIO_W-1:0] gpio_sync2;
    logic [31:0]       cnt;
    logic [31:0]       cmp;
    logic [31:0]       cnt_next;
    ctrl_t             ctrl;
    logic              match;
    logic              match_event;
    logic              overflow;
    logic              status_wr;
    logic [7:0]        status;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_push_ok;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;

    assign io_sel           = (DataAdr[31:8] == IO_BASE[31:8]);
    assign off              = DataAdr[7:2];
    assign io_wr            = MemWrite & io_sel;
    assign dmem_we          = MemWrite & ~io_sel;
    assign ReadData         = io_sel ? io_rdata : dmem_rd;
    assign unused_addr_bits = ^DataAdr[1:0];

    assign status_wr = io_wr & (off == OFF_STATUS);
    assign fifo_push = io_wr & (off == OFF_TX_DATA);
    assign fifo_pop  = tx_valid & tx_ready;
    assign tx_valid  = ~fifo_empty;
    assign timer_irq = match & ctrl.irq_en;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .push_data (WriteData[7:0]),
        .head      (tx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .push_ok   (fifo_push_ok)
    );

    // A CPU write to CNT overrides whatever the timer would have loaded.
    always_comb begin
        match_event = ctrl.timer_en & (cnt == cmp);
        cnt_next    = cnt;
        if (ctrl.timer_en) begin
            cnt_next = (match_event & ctrl.auto_clear) ? 32'd0 : cnt + 32'd1;
        end
        if (io_wr && (off == OFF_TIMER_CNT)) begin
            cnt_next = WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_out   <= '0;
            gpio_sync1 <= '0;
            gpio_sync2 <= '0;
            cnt        <= '0;
            cmp        <= 32'hFFFF_FFFF;
            ctrl       <= '0;
            match      <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            gpio_sync1 <= gpio_in;
            gpio_sync2 <= gpio_sync1;
            cnt        <= cnt_next;
            // Set beats the W1C clear when both land on the same edge.
            match      <= match_event |
                          (match & ~(status_wr & WriteData[ST_MATCH]));
            overflow   <= (fifo_push & ~fifo_push_ok) |
                          (overflow & ~(status_wr & WriteData[ST_OVERFLOW]));
            if (io_wr && (off == OFF_GPIO_OUT)) begin
                gpio_out <= WriteData[GPIO_W-1:0];
            end
            if (io_wr && (off == OFF_TIMER_CMP)) begin
                cmp <= WriteData;
            end
            if (io_wr && (off == OFF_CTRL)) begin
                ctrl <= ctrl_t'(WriteData[CTRL_IRQ_EN:CTRL_TIMER_EN]);
            end
        end
    end

    always_comb begin
        status                                = '0;
        status[ST_MATCH]                      = match;
        status[ST_FULL]                       = fifo_full;
        status[ST_EMPTY]                      = fifo_empty;
        status[ST_OVERFLOW]                   = overflow;
        status[ST_COUNT_LSB+3:ST_COUNT_LSB]   = 4'(fifo_count);
    end

    always_comb begin
        io_rdata = '0;
        case (off)
            OFF_GPIO_OUT:  io_rdata[GPIO_W-1:0] = gpio_out;
            OFF_GPIO_IN:   io_rdata[GPIO_W-1:0] = gpio_sync2;
            OFF_TIMER_CNT: io_rdata             = cnt;
            OFF_TIMER_CMP: io_rdata             = cmp;
            OFF_STATUS:    io_rdata[7:0]        = status;
            OFF_CTRL:      io_rdata[2:0]        = ctrl;
            default:       io_rdata             = '0;
        endcase
    end

endmodule
